// File: rtl/cpu_control_sequencer_if.sv
// rtl/cpu_control_sequencer_if.sv - control, decode and memory-handshake signals of the Reptile-8 sequencer
interface cpu_control_sequencer_if;
  logic        run;
  logic [11:0] ir;
  logic        zero_flag;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        ir_load;
  logic        pc_inc;
  logic        pc_rel;
  logic        alu_en;
  logic        reg_we;
  logic        wb_sel;
  logic        halted;
  logic        fault;

  // sequencer side
  modport master (
    input  run, ir, zero_flag, mem_ready,
    output mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_rel,
           alu_en, reg_we, wb_sel, halted, fault
  );

  // datapath / memory side
  modport slave (
    output run, ir, zero_flag, mem_ready,
    input  mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_rel,
           alu_en, reg_we, wb_sel, halted, fault
  );
endinterface

// File: rtl/cpu_control_sequencer.sv
// rtl/cpu_control_sequencer.sv - multi-cycle fetch/decode/execute control FSM for the Reptile-8 core
module cpu_control_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cpu_control_sequencer_if.master       bus
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC, WB, MEM, LWB, BRANCH, HALT, FAULT
  } stateT;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  stateT      state;
  stateT      nextState;
  logic [7:0] timeoutCnt;
  logic       memReq;
  logic       memWe;
  logic       addrSel;
  logic       pcRel;
  logic       aluEn;
  logic       regWe;
  logic       wbSel;
  logic       halted;
  logic       fault;

  logic       isHalt;
  logic       isAlu;
  logic       isLoadStore;
  logic       isStore;
  logic       isJmp;
  logic       timedOut;

  // HALT is the all-ones encoding and takes priority over BZ
  assign isHalt      = (bus.ir == 12'hFFF);
  assign isAlu       = ~bus.ir[11];
  assign isLoadStore = (bus.ir[11:10] == 2'b10);
  assign isStore     = (bus.ir[11:9] == 3'b101);
  assign isJmp       = (bus.ir[11:9] == 3'b110);

  // this stalled cycle would be the TIMEOUT-th one, so give up on the memory
  assign timedOut    = !bus.mem_ready && (timeoutCnt == TIMEOUT_LAST);

  // next-state selection; HALT and FAULT only leave through reset
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.run) nextState = FETCH;
      FETCH: begin
        if (bus.mem_ready)  nextState = DECODE;
        else if (timedOut)  nextState = FAULT;
      end
      DECODE: begin
        if (isHalt)           nextState = HALT;
        else if (isAlu)       nextState = EXEC;
        else if (isLoadStore) nextState = MEM;
        else                  nextState = BRANCH;
      end
      EXEC:    nextState = WB;
      WB:      nextState = IDLE;
      MEM: begin
        if (bus.mem_ready)  nextState = isStore ? IDLE : LWB;
        else if (timedOut)  nextState = FAULT;
      end
      LWB:     nextState = IDLE;
      BRANCH:  nextState = IDLE;
      HALT:    nextState = HALT;
      FAULT:   nextState = FAULT;
      default: nextState = IDLE;
    endcase
  end

  // state, timeout counter and Moore strobes registered from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timeoutCnt <= 8'd0;
      memReq     <= 1'b0;
      memWe      <= 1'b0;
      addrSel    <= 1'b0;
      pcRel      <= 1'b0;
      aluEn      <= 1'b0;
      regWe      <= 1'b0;
      wbSel      <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state   <= nextState;
      memReq  <= (nextState == FETCH) || (nextState == MEM);
      memWe   <= (nextState == MEM) && isStore;
      addrSel <= (nextState == MEM);
      aluEn   <= (nextState == EXEC);
      regWe   <= (nextState == WB) || (nextState == LWB);
      wbSel   <= (nextState == LWB);
      pcRel   <= (nextState == BRANCH) && (isJmp || bus.zero_flag);
      halted  <= (nextState == HALT);
      fault   <= (nextState == FAULT);
      if ((nextState != state) && ((nextState == FETCH) || (nextState == MEM)))
        timeoutCnt <= 8'd0;
      else if (memReq && !bus.mem_ready)
        timeoutCnt <= timeoutCnt + 8'd1;
    end
  end

  // fetch completion strobes follow mem_ready in the same cycle
  assign bus.ir_load  = (state == FETCH) && bus.mem_ready;
  assign bus.pc_inc   = (state == FETCH) && bus.mem_ready;
  assign bus.mem_req  = memReq;
  assign bus.mem_we   = memWe;
  assign bus.addr_sel = addrSel;
  assign bus.pc_rel   = pcRel;
  assign bus.alu_en   = aluEn;
  assign bus.reg_we   = regWe;
  assign bus.wb_sel   = wbSel;
  assign bus.halted   = halted;
  assign bus.fault    = fault;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// tb/tb_cpu_control_sequencer.sv - scoreboard bench for cpu_control_sequencer
`timescale 1ns/1ps
module tb_cpu_control_sequencer;

  // output vector bit order: {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_rel, alu_en, reg_we, wb_sel, halted, fault}
  localparam logic [10:0] REQ  = 11'h400;
  localparam logic [10:0] WE   = 11'h200;
  localparam logic [10:0] ASEL = 11'h100;
  localparam logic [10:0] IRL  = 11'h080;
  localparam logic [10:0] PCI  = 11'h040;
  localparam logic [10:0] PCR  = 11'h020;
  localparam logic [10:0] ALU  = 11'h010;
  localparam logic [10:0] RWE  = 11'h008;
  localparam logic [10:0] WBS  = 11'h004;
  localparam logic [10:0] HLT  = 11'h002;
  localparam logic [10:0] FLT  = 11'h001;
  localparam logic [10:0] Z    = 11'h000;
  localparam logic [10:0] F    = REQ | IRL | PCI;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cpu_control_sequencer_if bus();

  cpu_control_sequencer #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [10:0] outVec;
  assign outVec = {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_load, bus.pc_inc, bus.pc_rel,
                   bus.alu_en, bus.reg_we, bus.wb_sel, bus.halted, bus.fault};

  logic [10:0] expQ[$];
  int testsRun = 0;
  int testsFailed = 0;

  // drive one cycle of stimulus just after the edge and queue what that cycle must show
  task automatic driveCycle(input logic r, input logic [11:0] i, input logic zf,
                            input logic rdy, input logic [10:0] e);
    @(posedge clk);
    #1;
    bus.run       = r;
    bus.ir        = i;
    bus.zero_flag = zf;
    bus.mem_ready = rdy;
    expQ.push_back(e);
  endtask

  task automatic test_reset();
    logic [10:0] e;
    logic [10:0] ex [4];
    logic [10:0] ex2 [8];
    logic [7:0]  runV;
    bus.run = 1'b0; bus.ir = 12'h000; bus.zero_flag = 1'b0; bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (outVec !== Z) begin
      testsFailed++;
      $display("FAIL reset_state: got %b expected %b", outVec, Z);
    end
    rst_n = 1'b1;
    // LOAD with memory stalled so the FSM sits in MEM with mem_req high
    ex = '{Z, F, Z, REQ | ASEL};
    for (int k = 0; k < 4; k++) begin
      driveCycle(k == 0, 12'h80A, 1'b0, k == 1, ex[k]);
      @(negedge clk);
      e = expQ.pop_front();
      testsRun++;
      if (outVec !== e) begin
        testsFailed++;
        $display("FAIL reset_into_mem cycle %0d: got %b expected %b", k + 1, outVec, e);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    testsRun++;
    if (outVec !== Z) begin
      testsFailed++;
      $display("FAIL reset_async_clear: got %b expected %b", outVec, Z);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // back in IDLE: holds while run=0, then a full zero-wait LOAD
    runV = 8'b00000100;
    ex2 = '{Z, Z, Z, F, Z, REQ | ASEL, RWE | WBS, Z};
    for (int k = 0; k < 8; k++) begin
      driveCycle(runV[k], 12'h80A, 1'b0, 1'b1, ex2[k]);
      @(negedge clk);
      e = expQ.pop_front();
      testsRun++;
      if (outVec !== e) begin
        testsFailed++;
        $display("FAIL reset_release cycle %0d: got %b expected %b", k + 1, outVec, e);
      end
    end
  endtask

  task automatic test_alu();
    logic [10:0] e;
    logic [10:0] ex [6];
    ex = '{Z, F, Z, ALU, RWE, Z};
    for (int k = 0; k < 6; k++) begin
      driveCycle(k == 0, 12'h0D3, 1'b0, 1'b1, ex[k]);
      @(negedge clk);
      e = expQ.pop_front();
      testsRun++;
      if (outVec !== e) begin
        testsFailed++;
        $display("FAIL alu cycle %0d: got %b expected %b", k + 1, outVec, e);
      end
    end
  endtask

  task automatic test_load_wait();
    logic [10:0] e;
    logic [10:0] ex [9];
    logic [8:0]  rdyV;
    rdyV = 9'b111000111;
    ex = '{Z, F, Z, REQ | ASEL, REQ | ASEL, REQ | ASEL, REQ | ASEL, RWE | WBS, Z};
    for (int k = 0; k < 9; k++) begin
      driveCycle(k == 0, 12'h80A, 1'b0, rdyV[k], ex[k]);
      @(negedge clk);
      e = expQ.pop_front();
      testsRun++;
      if (outVec !== e) begin
        testsFailed++;
        $display("FAIL load_wait cycle %0d: got %b expected %b", k + 1, outVec, e);
      end
    end
  endtask

  task automatic test_store();
    logic [10:0] e;
    logic [10:0] ex [5];
    ex = '{Z, F, Z, REQ | WE | ASEL, Z};
    for (int k = 0; k < 5; k++) begin
      driveCycle(k == 0, 12'hA00, 1'b0, 1'b1, ex[k]);
      @(negedge clk);
      e = expQ.pop_front();
      testsRun++;
      if (outVec !== e) begin
        testsFailed++;
        $display("FAIL store cycle %0d: got %b expected %b", k + 1, outVec, e);
      end
    end
  endtask

  task automatic test_branch();
    logic [10:0] e;
    logic [11:0] irV [3];
    logic [2:0]  zfV;
    logic [10:0] brV [3];
    logic [10:0] ex [5];
    irV = '{12'hE05, 12'hE05, 12'hC05};
    zfV = 3'b010;
    brV = '{Z, PCR, PCR};
    for (int v = 0; v < 3; v++) begin
      ex = '{Z, F, Z, brV[v], Z};
      for (int k = 0; k < 5; k++) begin
        driveCycle(k == 0, irV[v], zfV[v], 1'b1, ex[k]);
        @(negedge clk);
        e = expQ.pop_front();
        testsRun++;
        if (outVec !== e) begin
          testsFailed++;
          $display("FAIL branch%0d cycle %0d: got %b expected %b", v, k + 1, outVec, e);
        end
      end
    end
  endtask

  task automatic test_run_drop();
    logic [10:0] e;
    logic [10:0] ex [14];
    logic [13:0] runV;
    runV = 14'b00000100000111;
    ex = '{Z, F, Z, ALU, RWE, Z, Z, Z, Z, F, Z, ALU, RWE, Z};
    for (int k = 0; k < 14; k++) begin
      driveCycle(runV[k], 12'h0D3, 1'b0, 1'b1, ex[k]);
      @(negedge clk);
      e = expQ.pop_front();
      testsRun++;
      if (outVec !== e) begin
        testsFailed++;
        $display("FAIL run_drop cycle %0d: got %b expected %b", k + 1, outVec, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] e;
    logic [10:0] ex [10];
    logic [9:0]  runV;
    runV = 10'b0000111111;
    ex = '{Z, F, Z, ALU, RWE, Z, F, Z, REQ | WE | ASEL, Z};
    for (int k = 0; k < 10; k++) begin
      driveCycle(runV[k], (k < 5) ? 12'h0D3 : 12'hA00, 1'b0, 1'b1, ex[k]);
      @(negedge clk);
      e = expQ.pop_front();
      testsRun++;
      if (outVec !== e) begin
        testsFailed++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", k + 1, outVec, e);
      end
    end
  endtask

  task automatic test_halt();
    logic [10:0] e;
    for (int k = 0; k < 10; k++) begin
      driveCycle(1'b1, 12'hFFF, 1'b1, 1'b1, (k == 1) ? F : ((k >= 3) ? HLT : Z));
      @(negedge clk);
      e = expQ.pop_front();
      testsRun++;
      if (outVec !== e) begin
        testsFailed++;
        $display("FAIL halt cycle %0d: got %b expected %b", k + 1, outVec, e);
      end
    end
  endtask

  task automatic test_timeout();
    logic [10:0] e;
    logic [10:0] ex [8];
    logic [7:0]  rdyV;
    @(negedge clk);
    bus.run = 1'b0;
    rst_n = 1'b0;
    #2;
    testsRun++;
    if (outVec !== Z) begin
      testsFailed++;
      $display("FAIL timeout_reset_clear: got %b expected %b", outVec, Z);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rdyV = 8'b11100000;
    ex = '{Z, REQ, REQ, REQ, REQ, FLT, FLT, FLT};
    for (int k = 0; k < 8; k++) begin
      driveCycle(1'b1, 12'h000, 1'b0, rdyV[k], ex[k]);
      @(negedge clk);
      e = expQ.pop_front();
      testsRun++;
      if (outVec !== e) begin
        testsFailed++;
        $display("FAIL timeout cycle %0d: got %b expected %b", k + 1, outVec, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_branch();
    test_run_drop();
    test_back_to_back();
    test_halt();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
